// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in/serial-out word serializer with valid/ready load,
//            downstream hold, inter-frame gap and frame status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH      = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             hold,
    output logic             data_out,
    output logic             enable_out,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_count
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(WIDTH - 1);
    localparam bit                 c_has_gap  = (GAP_CYCLES > 0);
    localparam logic [3:0]         c_gap_last = c_has_gap ? 4'(GAP_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_gap   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic               w_head;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic               r_frame_done;
    logic [7:0]         r_frame_count;
    logic               w_accept;
    logic               w_advance;
    logic               w_last_bit;

    // Output end of the shift register and the zero-filled shift toward it
    if (MSB_FIRST) begin : g_msb_first
        assign w_head       = r_shift[WIDTH-1];
        assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
        assign w_head       = r_shift[0];
        assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
    end

    assign w_accept   = load_valid && load_ready;
    assign w_advance  = (r_state == c_st_shift) && !hold;
    assign w_last_bit = w_advance && (r_bit_cnt == c_bit_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_next_state = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_last_bit) begin
                    w_next_state = c_has_gap ? c_st_gap : c_st_idle;
                end
            end
            c_st_gap: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // load_ready is gated by reset directly so it stays low for the whole reset pulse
    always_comb begin
        load_ready  = (r_state == c_st_idle) && !reset;
        busy        = (r_state != c_st_idle);
        data_out    = (r_state == c_st_shift) ? w_head : 1'b0;
        enable_out  = (r_state == c_st_shift) && !hold;
        frame_done  = r_frame_done;
        frame_count = r_frame_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_shift   <= load_data;
                        r_bit_cnt <= '0;
                    end
                end
                c_st_shift: begin
                    if (w_advance) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    if (w_last_bit) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                        r_gap_cnt     <= 4'd0;
                    end
                end
                c_st_gap: begin
                    r_gap_cnt <= r_gap_cnt + 4'd1;
                end
                default: begin
                    r_gap_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Brief    : Self-checking bench for piso_serializer (MSB-first and LSB-first
//            instances sharing stimulus) with a word-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    localparam int W   = 4;
    localparam int GAP = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         hold = 1'b0;

    logic       ready_a, dout_a, en_a, busy_a, done_a;
    logic [7:0] cnt_a;
    logic       ready_b, dout_b, en_b, busy_b, done_b;
    logic [7:0] cnt_b;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP)) dut_a (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_a), .hold(hold), .data_out(dout_a), .enable_out(en_a),
        .busy(busy_a), .frame_done(done_a), .frame_count(cnt_a)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP)) dut_b (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_b), .hold(hold), .data_out(dout_b), .enable_out(en_b),
        .busy(busy_b), .frame_done(done_b), .frame_count(cnt_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int model_count = 0;
    bit q_a[$];
    bit q_b[$];
    int done_cycles[$];
    logic [W-1:0] exp_words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] reverse(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    // Bits seen with enable high are what the downstream SIPO consumes at the next edge
    task automatic cyc();
        if (en_a) q_a.push_back(dout_a);
        if (en_b) q_b.push_back(dout_b);
        @(posedge clk);
        #1;
        cycle++;
        if (done_a) done_cycles.push_back(cycle);
    endtask

    // Word as seen by a SIPO shifting in at the LSB, from the last W captured bits
    function automatic logic [W-1:0] sipo_tail(input bit q[$]);
        logic [W-1:0] s = '0;
        for (int i = 0; i < W; i++) begin
            if (q.size() >= W) s = {s[W-2:0], q[q.size()-W+i]};
        end
        return s;
    endfunction

    task automatic send_frame(input logic [W-1:0] word, input int hold_at, input int hold_len);
        int k;
        int bits;
        int held;
        int t;
        int n_done;
        t = 0;
        while (!ready_a && t < 50) begin
            cyc();
            t++;
        end
        check("ready_before_load", ready_a, 1);
        n_done = done_cycles.size();
        load_data  = word;
        load_valid = 1'b1;
        k = cycle + 1;
        cyc();
        load_valid = 1'b0;
        load_data  = W'($urandom);
        check("ready_low_in_frame", ready_a, 0);
        check("busy_in_frame", busy_a, 1);
        bits = 0;
        held = 0;
        while (bits < W) begin
            hold = (bits == hold_at) && (held < hold_len);
            #1;
            check("dout_msb", dout_a, word[W-1-bits]);
            check("dout_lsb", dout_b, word[bits]);
            check("enable", en_a, !hold);
            check("count_during", cnt_a, model_count % 256);
            if (hold) held++;
            else bits++;
            cyc();
        end
        model_count++;
        // Frame status appears in the cycle right after the last consumed bit
        check("frame_done_pulse", done_a, 1);
        check("frame_done_cycle", (done_cycles.size() > 0) ? done_cycles[$] : -1, k + W + held);
        check("frame_count", cnt_a, model_count % 256);
        check("enable_after", en_a, 0);
        check("dout_after", dout_a, 0);
        check("busy_after", busy_a, (GAP > 0) ? 1 : 0);
        check("sipo_msb", sipo_tail(q_a), word);
        check("sipo_lsb", sipo_tail(q_b), reverse(word));
        hold = 1'b1;
        cyc();
        check("frame_done_single", done_a, 0);
        check("done_count", done_cycles.size(), n_done + 1);
        hold = $urandom_range(0, 1);
    endtask

    initial begin
        int n_done;
        int nacc;
        int last;
        int cnt_before;
        bit acc;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;

        // Reset values
        #1 reset = 1'b1;
        #1;
        check("rst_ready", ready_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_enable", en_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_done", done_a, 0);
        check("rst_count", cnt_a, 0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        check("ready_after_rst", ready_a, 1);
        check("count_after_rst", cnt_a, 0);

        // Directed frames, plain and with a two-cycle hold before the third bit
        send_frame(4'b1011, W, 0);
        send_frame(4'b1011, 2, 2);
        send_frame(4'b0110, 0, 3);
        send_frame(4'b1001, W - 1, 1);

        // Randomized frames with random idle, hold position and length
        for (int f = 0; f < 24; f++) begin
            hold = $urandom_range(0, 1);
            repeat ($urandom_range(0, 3)) cyc();
            send_frame(W'($urandom), $urandom_range(0, W - 1), $urandom_range(0, 3));
        end

        // Back-to-back words with load_valid held high; 256 frames wrap the count
        hold = 1'b0;
        while (busy_a) cyc();
        q_a.delete();
        q_b.delete();
        exp_words.delete();
        n_done = done_cycles.size();
        cnt_before = cnt_a;
        load_data  = 4'hA;
        load_valid = 1'b1;
        nacc = 0;
        last = 0;
        for (int t = 0; t < 256 * (W + 1 + GAP) + 20 && nacc < 256; t++) begin
            acc = ready_a;
            if (acc) exp_words.push_back(load_data);
            cyc();
            if (acc) begin
                if (nacc > 0) check("b2b_spacing", cycle - last, W + 1 + GAP);
                last = cycle;
                nacc++;
                load_data = (nacc == 1) ? 4'h5 : W'($urandom);
                if (nacc == 256) load_valid = 1'b0;
                else begin
                    #1;
                    check("ready_low_after_accept", ready_a, 0);
                end
            end
        end
        check("b2b_accepted", nacc, 256);
        repeat (W + GAP + 2) cyc();
        model_count += 256;
        check("wrap_count", cnt_a, cnt_before);
        check("wrap_model", cnt_a, model_count % 256);
        check("b2b_done_pulses", done_cycles.size(), n_done + 256);
        check("b2b_bits", q_a.size(), 256 * W);
        for (int j = 0; j < exp_words.size(); j++) begin
            if ((j + 1) * W <= q_a.size() && (j + 1) * W <= q_b.size()) begin
                s_a = '0;
                s_b = '0;
                for (int i = 0; i < W; i++) begin
                    s_a = {s_a[W-2:0], q_a[j*W+i]};
                    s_b = {s_b[W-2:0], q_b[j*W+i]};
                end
                check("b2b_word_msb", s_a, exp_words[j]);
                check("b2b_word_lsb", s_b, reverse(exp_words[j]));
            end
        end

        // Reset after two bits of a frame aborts it without status
        while (!ready_a) cyc();
        n_done = done_cycles.size();
        load_data  = 4'b1111;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        cyc();
        cyc();
        #2 reset = 1'b1;
        #1;
        check("abort_enable", en_a, 0);
        check("abort_dout", dout_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_ready", ready_a, 0);
        check("abort_count", cnt_a, 0);
        cyc();
        cyc();
        reset = 1'b0;
        model_count = 0;
        #1;
        check("abort_ready_after", ready_a, 1);
        cyc();
        check("abort_no_done", done_cycles.size(), n_done);
        check("abort_count_after", cnt_a, 0);
        send_frame(W'($urandom), 1, 1);
        check("fresh_count", cnt_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
